// File: rtl/fetch_queue_if.sv
// Port bundle for fetch_queue: PC-stage request/stall, instruction-memory port, decode handshake.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32
);
  logic [AW-1:0]            pc_i;
  logic                     pc_ce_i;
  logic                     flush_i;
  logic                     stall_pc_o;
  logic                     imem_en_o;
  logic [AW-1:0]            imem_addr_o;
  logic [DW-1:0]            imem_rdata_i;
  logic                     id_valid_o;
  logic                     id_ready_i;
  logic [DW-1:0]            id_inst_o;
  logic [AW-1:0]            id_pc_o;
  logic                     id_exc_o;
  logic [$clog2(DEPTH):0]   count_o;

  // Fetch-queue side.
  modport master (
    input  pc_i, pc_ce_i, flush_i, imem_rdata_i, id_ready_i,
    output stall_pc_o, imem_en_o, imem_addr_o, id_valid_o, id_inst_o, id_pc_o, id_exc_o,
           count_o
  );

  // PC stage / memory / decode side.
  modport slave (
    output pc_i, pc_ce_i, flush_i, imem_rdata_i, id_ready_i,
    input  stall_pc_o, imem_en_o, imem_addr_o, id_valid_o, id_inst_o, id_pc_o, id_exc_o,
           count_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch queue: issues 1-cycle imem reads and buffers {pc, inst} pairs for decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned PCs enqueue a NOP tagged with a fetch exception.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DepthCredit = (CW+1)'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [DW-1:0] inst_mem [DEPTH];
  logic [AW-1:0] pc_mem [DEPTH];
  logic [DW-1:0] push_inst;
  logic [CW:0]   credit;
  logic          id_valid, pop, push, issue, misaligned;

  assign id_valid = (count_q != '0);
  assign pop      = id_valid & bus.id_ready_i & ~bus.flush_i;
  // Returning data lands one cycle after issue; flush discards it.
  assign push     = inflight_q & ~bus.flush_i;

  // Occupancy plus the outstanding read, with this cycle's pop already freeing its slot.
  assign credit = {1'b0, count_q} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inflight_q};
  assign issue  = rst & bus.pc_ce_i & ~bus.flush_i & (credit < DepthCredit);

  assign bus.stall_pc_o  = rst & bus.pc_ce_i & ~bus.flush_i & ~issue;
  assign bus.imem_en_o   = issue & ~misaligned;
  assign bus.imem_addr_o = {bus.pc_i[AW-1:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_exc_q;
  logic fetch_exc_d;
  logic exc_mem [DEPTH];

  assign misaligned  = (bus.pc_i[1:0] != 2'b00);
  assign fetch_pc_d  = issue ? bus.pc_i : fetch_pc_q;
  assign fetch_exc_d = issue ? misaligned : fetch_exc_q;
  // A faulting fetch never read memory; it occupies its slot as a NOP.
  assign push_inst   = fetch_exc_q ? '0 : bus.imem_rdata_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_exc_q <= 1'b0;
    end else begin
      fetch_exc_q <= fetch_exc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      exc_mem[wr_ptr_q] <= fetch_exc_q;
    end
  end

  assign bus.id_exc_o = id_valid & exc_mem[rd_ptr_q];
`else
  logic unused_pc_lsb;

  assign unused_pc_lsb = ^bus.pc_i[1:0];
  assign misaligned    = 1'b0;
  assign fetch_pc_d    = issue ? {bus.pc_i[AW-1:2], 2'b00} : fetch_pc_q;
  assign push_inst     = bus.imem_rdata_i;
  assign bus.id_exc_o  = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      fetch_pc_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= issue;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= push_inst;
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  // Storage is not reset, so empty-queue outputs are forced to zero.
  assign bus.id_valid_o = id_valid;
  assign bus.id_inst_o  = id_valid ? inst_mem[rd_ptr_q] : '0;
  assign bus.id_pc_o    = id_valid ? pc_mem[rd_ptr_q] : '0;
  assign bus.count_o    = count_q;
endmodule
